// File: rtl/tremolo_modulator.sv
// tremolo_modulator
// Applies a triangle LFO as an amplitude envelope to a 16-bit signed audio
// stream. One sample is accepted per i_valid strobe while o_ready is high.
// With the effect disabled the sample is passed straight through (1 cycle).
// With the effect enabled the sample walks a 3-stage pipeline (gain,
// product, output), so o_valid rises 3 cycles after the capture edge.
//
// state  | meaning
// S_IDLE | waiting for a sample, o_ready=1
// S_GAIN | captured operands, computing gain
// S_MUL  | gain registered, computing data*gain
// S_OUT  | product registered, writing o_data
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_start    effect enable (0 = bypass)
//   i_depth    modulation depth code, saturated to DEPTH_FULL
//   i_tri      signed LFO value from the triangle generator
//   i_valid    one-cycle strobe qualifying i_data / i_tri
//   i_data     signed audio sample in
//   o_ready    high when a new sample will be accepted
//   o_valid    one-cycle strobe, o_data updated
//   o_data     signed modulated sample, held between strobes
//   o_overrun  sticky: a sample arrived while busy and was dropped
module tremolo_modulator #(
  parameter int DEPTH_W    = 4,
  parameter int DEPTH_FULL = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [DEPTH_W-1:0]   i_depth,
  input  logic signed [15:0]   i_tri,
  input  logic                 i_valid,
  input  logic signed [15:0]   i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic signed [15:0]   o_data,
  output logic                 o_overrun
);

  localparam int DEPTH_SHIFT = $clog2(DEPTH_FULL);
  localparam int SCALE_W     = DEPTH_W + 15;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH_FULL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAIN,
    S_MUL,
    S_OUT
  } state_t;

  state_t state, state_next;

  logic signed [15:0]  data_r;
  logic [14:0]         lfo_r;
  logic [DEPTH_W-1:0]  depth_r;
  logic [14:0]         gain_r;
  logic signed [31:0]  prod_r;
  logic                start_q;

  logic                start_rise;
  logic                busy_drop;
  logic [SCALE_W-1:0]  scaled;
  logic [14:0]         gain_next;
  logic signed [31:0]  prod_next;

  assign start_rise = i_start & ~start_q;
  assign busy_drop  = (state != S_IDLE) & i_valid;

  // Depth 0 leaves gain at full scale; depth FULL lets gain follow the LFO
  // all the way down to 0 when the (clamped) LFO is 0.
  assign scaled    = SCALE_W'(depth_r) * SCALE_W'(15'h7FFF - lfo_r);
  assign gain_next = 15'h7FFF - 15'(scaled >> DEPTH_SHIFT);

  // gain is non-negative, so it is zero-extended before the signed multiply.
  assign prod_next = $signed({{16{data_r[15]}}, data_r}) * $signed({17'd0, gain_r});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid && i_start) state_next = S_GAIN;
      end
      S_GAIN:  state_next = S_MUL;
      S_MUL:   state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_r    <= '0;
      lfo_r     <= '0;
      depth_r   <= '0;
      gain_r    <= '0;
      prod_r    <= '0;
      start_q   <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      start_q <= i_start;
      o_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_valid) begin
            if (i_start) begin
              data_r  <= i_data;
              lfo_r   <= i_tri[15] ? 15'd0 : i_tri[14:0];
              depth_r <= (i_depth > DEPTH_MAX) ? DEPTH_MAX : i_depth;
            end else begin
              o_data  <= i_data;
              o_valid <= 1'b1;
            end
          end
        end
        S_GAIN: gain_r <= gain_next;
        S_MUL:  prod_r <= prod_next;
        S_OUT: begin
          o_data  <= 16'(prod_r >>> 15);
          o_valid <= 1'b1;
        end
        default: ;
      endcase

      // A fresh enable clears the sticky flag even if a drop happens on
      // the same edge.
      if (start_rise) begin
        o_overrun <= 1'b0;
      end else if (busy_drop) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tremolo_modulator.sv
// Directed bench for tremolo_modulator: bypass, modulation vectors, depth
// saturation, overrun handling, enable edges and asynchronous reset.
module tb_tremolo_modulator;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [3:0]         i_depth;
  logic signed [15:0] i_tri;
  logic               i_valid;
  logic signed [15:0] i_data;
  logic               o_ready;
  logic               o_valid;
  logic signed [15:0] o_data;
  logic               o_overrun;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tremolo_modulator #(.DEPTH_W(4), .DEPTH_FULL(8)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_depth   (i_depth),
    .i_tri     (i_tri),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_overrun (o_overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b0; i_depth = 4'd0; i_tri = 16'sd0;
    i_valid = 1'b0; i_data = 16'sd0;
    #2;
    checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready); else passes++;
    checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else passes++;
    checks++; if (o_data !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", o_data); else passes++;
    checks++; if (o_overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", o_overrun); else passes++;
    tick; tick;
    #2 i_rst = 1'b0;
    tick;
  endtask

  task automatic test_bypass;
    i_start = 1'b0; i_valid = 1'b1; i_data = 16'h1234;
    tick;
    i_valid = 1'b0; i_data = 16'h0000;
    checks++; if (o_valid !== 1'b1) $display("FAIL bypass_valid: got %b expected 1", o_valid); else passes++;
    checks++; if (o_data !== 16'h1234) $display("FAIL bypass_data: got %h expected 1234", o_data); else passes++;
    checks++; if (o_ready !== 1'b1) $display("FAIL bypass_ready: got %b expected 1", o_ready); else passes++;
    tick;
    checks++; if (o_valid !== 1'b0) $display("FAIL bypass_pulse: got %b expected 0", o_valid); else passes++;
    checks++; if (o_data !== 16'h1234) $display("FAIL bypass_hold: got %h expected 1234", o_data); else passes++;
  endtask

  task automatic test_mod(input string name, input logic [15:0] data_v,
                          input logic [15:0] tri_v, input logic [3:0] depth_v,
                          input logic [15:0] exp_v);
    i_start = 1'b1; i_valid = 1'b1; i_data = data_v; i_tri = tri_v; i_depth = depth_v;
    tick;
    // Post-capture operand changes must have no effect.
    i_valid = 1'b0; i_data = 16'h0101; i_tri = 16'h7FFF; i_depth = 4'd0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_ready !== 1'b0 || o_valid !== 1'b0)
        $display("FAIL %s_busy%0d: ready/valid got %b/%b expected 0/0", name, k, o_ready, o_valid);
      else passes++;
      tick;
    end
    checks++; if (o_valid !== 1'b1) $display("FAIL %s_valid: got %b expected 1", name, o_valid); else passes++;
    checks++; if (o_data !== exp_v) $display("FAIL %s_data: got %h expected %h", name, o_data, exp_v); else passes++;
    checks++; if (o_ready !== 1'b1) $display("FAIL %s_ready: got %b expected 1", name, o_ready); else passes++;
    tick;
    checks++; if (o_valid !== 1'b0 || o_data !== exp_v)
      $display("FAIL %s_hold: valid/data got %b/%h expected 0/%h", name, o_valid, o_data, exp_v);
    else passes++;
  endtask

  task automatic test_overrun;
    int pulses;
    logic [15:0] seen;
    pulses = 0; seen = 16'h0000;
    i_start = 1'b1; tick;
    i_valid = 1'b1; i_data = 16'h4000; i_tri = 16'h1000; i_depth = 4'd0;
    tick;
    i_data = 16'h1111;
    tick;
    i_valid = 1'b0;
    checks++; if (o_overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", o_overrun); else passes++;
    for (int k = 0; k < 6; k++) begin
      if (o_valid === 1'b1) begin pulses++; seen = o_data; end
      tick;
    end
    checks++; if (pulses != 1) $display("FAIL overrun_pulses: got %0d expected 1", pulses); else passes++;
    checks++; if (seen !== 16'h3FFF) $display("FAIL overrun_data: got %h expected 3fff", seen); else passes++;
    checks++; if (o_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", o_overrun); else passes++;
    i_start = 1'b0; tick;
    checks++; if (o_overrun !== 1'b1) $display("FAIL overrun_hold_low: got %b expected 1", o_overrun); else passes++;
    i_start = 1'b1; tick;
    checks++; if (o_overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", o_overrun); else passes++;
  endtask

  task automatic test_start_edges;
    // Capture, drop enable mid-flight, then re-enable together with a drop.
    i_start = 1'b1; i_valid = 1'b1; i_data = 16'h7FFF; i_tri = 16'h4000; i_depth = 4'd8;
    tick;
    i_valid = 1'b0; i_start = 1'b0;
    tick;
    i_start = 1'b1; i_valid = 1'b1; i_data = 16'h2222;
    tick;
    i_valid = 1'b0;
    checks++; if (o_overrun !== 1'b0) $display("FAIL clear_wins: got %b expected 0", o_overrun); else passes++;
    tick;
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h3FFF)
      $display("FAIL inflight_complete: valid/data got %b/%h expected 1/3fff", o_valid, o_data);
    else passes++;
    i_start = 1'b0; i_valid = 1'b1; i_data = 16'h5555;
    tick;
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h5555)
      $display("FAIL later_bypass: valid/data got %b/%h expected 1/5555", o_valid, o_data);
    else passes++;
    tick;
  endtask

  task automatic test_reset_mid;
    i_start = 1'b1; i_valid = 1'b1; i_data = 16'h7FFF; i_tri = 16'h4000; i_depth = 4'd8;
    tick;
    i_valid = 1'b0;
    #3 i_rst = 1'b1;
    #1;
    checks++; if (o_data !== 16'h0000) $display("FAIL rstmid_data: got %h expected 0000", o_data); else passes++;
    checks++; if (o_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", o_valid); else passes++;
    checks++; if (o_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", o_ready); else passes++;
    tick;
    #3 i_rst = 1'b0;
    tick;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (o_valid !== 1'b0) $display("FAIL rstmid_novalid%0d: got %b expected 0", k, o_valid);
      else passes++;
      tick;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_bypass;
    test_mod("zero_depth", 16'h4000, 16'h1000, 4'd0,  16'h3FFF);
    test_mod("full_pos",   16'h7FFF, 16'h4000, 4'd8,  16'h3FFF);
    test_mod("full_neg",   16'h8000, 16'h4000, 4'd8,  16'hC000);
    test_mod("neg_lfo",    16'h7FFF, 16'hF300, 4'd12, 16'h0000);
    test_overrun;
    test_start_edges;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tremolo_modulator.md
Name: tremolo_modulator

Overview:
- Consumes the signed 16-bit triangle LFO from the effect chain's triangle generator and applies it as an amplitude envelope to the audio sample stream (tremolo).
- Sits between the audio input path and the output path. Accepts one sample per i_valid pulse and emits one modulated sample per o_valid pulse.
- When the effect is disabled, samples pass through unmodified.

Parameters:
- DEPTH_W, 4, width of i_depth.
- DEPTH_FULL, 8, depth code for 100% modulation. Must be a power of two; its log2 (3) is the depth shift. Codes above it saturate to it.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, asynchronous, active-high
- i_start  input  1  effect enable; 0 = bypass
- i_depth  input  DEPTH_W  modulation depth code, 0..DEPTH_FULL
- i_tri  input  16 signed  LFO value from triangle generator
- i_valid  input  1  one-cycle strobe: i_data and i_tri valid
- i_data  input  16 signed  audio sample in
- o_ready  output  1  high when a new sample will be accepted
- o_valid  output  1  one-cycle strobe: o_data updated
- o_data  output  16 signed  modulated sample out; held between strobes
- o_overrun  output  1  sticky: a sample was dropped

Behaviour:
- Reset (async, i_rst=1): state=S_IDLE, o_valid=0, o_data=0, o_overrun=0, and all internal registers = 0. o_ready=1 after reset. Outputs go to reset values immediately, not on the next clock edge.
- States:
  - S_IDLE: o_ready=1.
  - S_GAIN, S_MUL, S_OUT: o_ready=0.
- Transitions from S_IDLE on an edge with i_valid=1:
  - If i_start=0 (bypass): o_data<=i_data, o_valid<=1 for one cycle, stay in S_IDLE. Latency is 1 cycle.
  - If i_start=1: capture i_data, i_tri and the saturated depth; go to S_GAIN.
- S_GAIN → S_MUL: register gain.
- S_MUL → S_OUT: register product.
- S_OUT → S_IDLE: o_data<=result, o_valid=1 for exactly one cycle. Latency from the capture edge to o_valid high is 3 cycles.
- Arithmetic (all on captured values):
  - lfo = (i_tri < 0) ? 0 : i_tri, giving an unsigned 15-bit value 0..32767.
  - d = min(i_depth, DEPTH_FULL).
  - gain = 32767 − ((d × (32767 − lfo)) >> 3). The intermediate is at least 19 bits unsigned. gain lies in 0..32767.
  - result = (i_data × gain) >>> 15, using a 32-bit signed product, an arithmetic shift and truncation toward −inf. No saturation is needed because gain < 2^15.
- i_valid while o_ready=0: the sample is dropped and o_overrun<=1. In-flight processing is unaffected.
- o_overrun clears on reset or on an i_start 0→1 transition, which is detected with a registered copy of i_start.
- i_start falling mid-computation: the in-flight sample completes with its captured gain. Later samples are bypassed.
- i_depth and i_tri changes are ignored except at the capture edge.
- Simultaneous overrun and i_start rising edge: the clear wins, so o_overrun=0.
- o_data never changes except on an o_valid cycle or a reset.

Test Plan:
- Bypass: i_start=0, i_valid pulse with i_data=0x1234 → o_valid high one cycle later with o_data=0x1234; o_ready stays 1.
- Zero depth: i_start=1, i_depth=0, i_tri=0x1000, i_data=0x4000 → o_ready low for 3 cycles; o_valid at latency 3; o_data=0x3FFF.
- Full depth, mid LFO: i_depth=8, i_tri=0x4000 (gain=16384):
  - i_data=0x7FFF → o_data=0x3FFF.
  - i_data=0x8000 → o_data=0xC000.
- Negative LFO and depth saturation: i_tri=−3328, i_depth=12 → treated as d=8, lfo=0, gain=0, o_data=0x0000 for i_data=0x7FFF.
- Overrun: i_start=1, i_valid on two consecutive cycles → exactly one o_valid, for the first sample; o_overrun=1 and stays 1. Toggling i_start 1→0→1 → o_overrun=0.
- Reset mid-operation: assert i_rst one cycle after capture, with no clock edge → o_data=0, o_valid=0 and o_ready=1 immediately. No o_valid follows after release.
